// File: rtl/bin_to_bcd_if.sv
// Handshake and data bundle between the adder-side producer and bin_to_bcd_seq.
// The hex_mode wire exists only when HEX_MODE_EN is defined.
interface bin_to_bcd_if #(
    parameter int WIDTH  = 9,
    parameter int DIGITS = 3
);
    logic                  start;
    logic [WIDTH-1:0]      value;
`ifdef HEX_MODE_EN
    logic                  hex_mode;
`endif
    logic                  busy;
    logic                  done;
    logic [4*DIGITS-1:0]   bcd;

`ifdef HEX_MODE_EN
    modport master (output start, value, hex_mode, input busy, done, bcd);
    modport slave  (input start, value, hex_mode, output busy, done, bcd);
`else
    modport master (output start, value, input busy, done, bcd);
    modport slave  (input start, value, output busy, done, bcd);
`endif
endinterface

// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter (double dabble, one bit per clock).
// Converts the 9-bit adder result into packed BCD digits for the display.
// Optional feature macro: HEX_MODE_EN adds a hex_mode input that bypasses
// conversion and loads the zero-extended raw value in a single cycle.
module bin_to_bcd_seq #(
    parameter int WIDTH  = 9,
    parameter int DIGITS = 3
) (
    input  logic              clk,
    input  logic              reset,
    bin_to_bcd_if.slave       bus
);
    localparam int BW = 4 * DIGITS;
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [WIDTH-1:0]  shift_q, shift_d;
    logic [BW-1:0]     scratch_q, scratch_d;
    logic [BW-1:0]     bcd_q, bcd_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [BW-1:0]     adj_s;

    // Add 3 to every nibble that is 5 or more, before it is doubled by the shift.
    function automatic logic [BW-1:0] add3_nibbles(input logic [BW-1:0] s);
        logic [BW-1:0] r;
        r = s;
        for (int i = 0; i < DIGITS; i++) begin
            if (s[4*i +: 4] >= 4'd5) begin
                r[4*i +: 4] = s[4*i +: 4] + 4'd3;
            end else begin
                r[4*i +: 4] = s[4*i +: 4];
            end
        end
        return r;
    endfunction

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.bcd  = bcd_q;

    // State register and datapath flops with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= {CW{1'b0}};
            shift_q   <= {WIDTH{1'b0}};
            scratch_q <= {BW{1'b0}};
            bcd_q     <= {BW{1'b0}};
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            shift_q   <= shift_d;
            scratch_q <= scratch_d;
            bcd_q     <= bcd_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    // Next-state logic: accept a start in IDLE, shift one bit per cycle in SHIFT.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        shift_d   = shift_q;
        scratch_d = scratch_q;
        bcd_d     = bcd_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        adj_s     = add3_nibbles(scratch_q);

        case (state_q)
            ST_IDLE: begin
                busy_d = 1'b0;
                if (bus.start) begin
`ifdef HEX_MODE_EN
                    if (bus.hex_mode) begin
                        // Raw hex bypass: result is ready at the next edge.
                        bcd_d              = {BW{1'b0}};
                        bcd_d[WIDTH-1:0]   = bus.value;
                        done_d             = 1'b1;
                    end else begin
                        shift_d   = bus.value;
                        scratch_d = {BW{1'b0}};
                        cnt_d     = CW'(WIDTH);
                        busy_d    = 1'b1;
                        state_d   = ST_SHIFT;
                    end
`else
                    shift_d   = bus.value;
                    scratch_d = {BW{1'b0}};
                    cnt_d     = CW'(WIDTH);
                    busy_d    = 1'b1;
                    state_d   = ST_SHIFT;
`endif
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                // Adjusted digits and the operand move left as one register.
                {scratch_d, shift_d} = {adj_s, shift_q} << 1;
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    // Last bit has been shifted in: publish and return to IDLE.
                    bcd_d   = scratch_d;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    cnt_d   = {CW{1'b0}};
                    state_d = ST_IDLE;
                end else begin
                    busy_d  = 1'b1;
                    state_d = ST_SHIFT;
                end
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
                cnt_d   = {CW{1'b0}};
            end
        endcase
    end
endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Directed testbench for bin_to_bcd_seq (WIDTH=9, DIGITS=3).
module tb_bin_to_bcd_seq;
    logic clk;
    logic reset;
    int   n_cmp;
    int   n_err;

    bin_to_bcd_if #(.WIDTH(9), .DIGITS(3)) bus ();

    bin_to_bcd_seq #(.WIDTH(9), .DIGITS(3)) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count one comparison and report it when observed differs from expected.
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Decimal reference built from division, independent of the shift-add method.
    function automatic logic [11:0] ref_bcd(input int v);
        return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    // Start a conversion from a negedge and wait for its done pulse (ends at a negedge).
    task automatic run_conv(input logic [8:0] v, input logic [11:0] exp,
                            input string tag, input bit full);
        int lat;
        bit got;
        bus.start = 1'b1;
        bus.value = v;
        @(negedge clk);
        bus.start = 1'b0;
        if (full) check({tag, "_busy_after_start"}, 32'(bus.busy), 32'd1);
        lat = 0;
        got = 1'b0;
        for (int k = 1; k <= 20 && !got; k++) begin
            @(negedge clk);
            if (bus.done) begin
                got = 1'b1;
                lat = k;
            end
        end
        if (full) begin
            check({tag, "_done_seen"}, 32'(got), 32'd1);
            check({tag, "_latency"}, 32'(lat), 32'd9);
            check({tag, "_busy_at_done"}, 32'(bus.busy), 32'd0);
        end else if (!got) begin
            check({tag, "_done_seen"}, 32'(got), 32'd1);
        end
        check({tag, "_bcd"}, 32'(bus.bcd), 32'(exp));
    endtask

    // Watch a number of cycles and return how many done pulses appeared.
    task automatic count_done(input int cycles, output int n);
        n = 0;
        for (int k = 0; k < cycles; k++) begin
            @(negedge clk);
            if (bus.done) n++;
        end
    endtask

    initial begin
        int  n;
        int  k;
        int  dones;
        bit  got;
        n_cmp = 0;
        n_err = 0;
        reset = 1'b1;
        bus.start = 1'b0;
        bus.value = 9'd0;
`ifdef HEX_MODE_EN
        bus.hex_mode = 1'b0;
`endif
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_bcd",  32'(bus.bcd),  32'd0);
        reset = 1'b0;
        @(negedge clk);

        run_conv(9'd255, 12'h255, "v255", 1'b1);
        run_conv(9'd0,   12'h000, "v0",   1'b1);
        run_conv(9'd511, 12'h511, "v511", 1'b1);
        run_conv(9'd9,   12'h009, "v9",   1'b1);
        run_conv(9'd10,  12'h010, "v10",  1'b1);
        run_conv(9'd99,  12'h099, "v99",  1'b1);
        run_conv(9'd100, 12'h100, "v100", 1'b1);
        run_conv(9'd256, 12'h256, "v256", 1'b1);

        for (int v = 0; v < 512; v++) begin
            run_conv(9'(v), ref_bcd(v), "sweep", 1'b0);
        end

        // Start while busy is ignored; value changes mid-conversion have no effect.
        bus.start = 1'b1;
        bus.value = 9'd123;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        bus.start = 1'b1;
        bus.value = 9'd400;
        @(negedge clk);
        bus.start = 1'b0;
        got = 1'b0;
        dones = 0;
        k = 3;
        while (!got && k < 25) begin
            @(negedge clk);
            k++;
            if (bus.done) begin
                got = 1'b1;
                dones++;
            end
        end
        check("ign_done_seen", 32'(got), 32'd1);
        check("ign_latency", 32'(k), 32'd9);
        check("ign_bcd", 32'(bus.bcd), 32'h123);
        // Start in the done cycle: accepted back to back.
        run_conv(9'd400, 12'h400, "b2b400", 1'b1);

        // Reset mid-conversion aborts it.
        bus.start = 1'b1;
        bus.value = 9'd511;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("abort_busy", 32'(bus.busy), 32'd0);
        check("abort_done", 32'(bus.done), 32'd0);
        check("abort_bcd",  32'(bus.bcd),  32'd0);
        count_done(12, n);
        check("abort_no_done", 32'(n), 32'd0);
        check("abort_bcd_hold", 32'(bus.bcd), 32'd0);
        run_conv(9'd42, 12'h042, "after_abort", 1'b1);

        // Reset and start together: reset wins.
        reset = 1'b1;
        bus.start = 1'b1;
        bus.value = 9'd77;
        @(negedge clk);
        reset = 1'b0;
        bus.start = 1'b0;
        check("rst_start_busy", 32'(bus.busy), 32'd0);
        count_done(12, n);
        check("rst_start_no_done", 32'(n), 32'd0);
        check("rst_start_bcd", 32'(bus.bcd), 32'd0);

`ifdef HEX_MODE_EN
        bus.hex_mode = 1'b1;
        bus.start = 1'b1;
        bus.value = 9'h1FF;
        @(negedge clk);
        bus.start = 1'b0;
        bus.hex_mode = 1'b0;
        check("hex_done", 32'(bus.done), 32'd1);
        check("hex_busy", 32'(bus.busy), 32'd0);
        check("hex_bcd",  32'(bus.bcd),  32'h1FF);
        @(negedge clk);
        check("hex_done_pulse", 32'(bus.done), 32'd0);
        run_conv(9'h1FF, 12'h511, "hex_off", 1'b1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
